// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
// Data bus width, FSM encodings and default queue depth.
package branch_resolution_unit_pkg;

  localparam int DataBusBits = 64;
  localparam int BRU_DEPTH   = 4;

  typedef enum logic {
    BRU_RUN   = 1'b0,
    BRU_FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [DataBusBits-1:0] pc;
    logic [DataBusBits-1:0] pred;
  } bru_entry_t;

endpackage

// File: rtl/branch_resolution_unit_adder.sv
// Plain combinational adder, wraps modulo 2^W.
// Used for the sequential PC+4 path.
module adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/branch_resolution_unit_pred_queue.sv
// In-order in-flight queue of fetched PC/prediction pairs.
// Wrap-bit pointers; clear has priority over push/pop.
module pred_queue
  import branch_resolution_unit_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  bru_entry_t din_i,
  output logic       full_o,
  output logic       empty_o,
  output bru_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  bru_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &
                   (wr_q[AW] != rd_q[AW]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // next pointer values
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
    end
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves predicted next-PCs at execute, trains the predictor,
// and raises a one-cycle flush with redirect on mispredict.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [DataBusBits-1:0] fetch_PC,
  input  logic [DataBusBits-1:0] fetch_PCPrediction,
  output logic                   fetch_ready,
  input  logic                   ex_valid,
  input  logic                   ex_isCF,
  input  logic                   ex_taken,
  input  logic [DataBusBits-1:0] ex_target,
  output logic                   we,
  output logic [DataBusBits-1:0] PCUpdate,
  output logic [DataBusBits-1:0] targetUpdate,
  output logic                   takenUpdate,
  output logic                   flush,
  output logic [DataBusBits-1:0] redirectPC,
  output logic [CNT_W-1:0]       branchCount,
  output logic [CNT_W-1:0]       mispredictCount,
  output logic                   protocol_error
);

  bru_state_e state_q, state_d;

  logic       q_full, q_empty;
  logic       push, pop, clear;
  bru_entry_t head, din;

  logic [DataBusBits-1:0] pc_plus4;
  logic [DataBusBits-1:0] actual_next;
  logic                   run, resolve, mispredict;

  logic                   we_q, we_d;
  logic [DataBusBits-1:0] pcu_q, pcu_d;
  logic [DataBusBits-1:0] tgt_q, tgt_d;
  logic                   tkn_q, tkn_d;
  logic                   flush_q, flush_d;
  logic [DataBusBits-1:0] redir_q, redir_d;
  logic [CNT_W-1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0]       mcnt_q, mcnt_d;
  logic                   perr_q, perr_d;

  assign din.pc   = fetch_PC;
  assign din.pred = fetch_PCPrediction;

  pred_queue #(
    .DEPTH (DEPTH)
  ) u_q (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .din_i   (din),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  adder #(
    .W (DataBusBits)
  ) u_pc4 (
    .a_i   (head.pc),
    .b_i   (DataBusBits'(4)),
    .sum_o (pc_plus4)
  );

  assign run         = (state_q == BRU_RUN);
  assign resolve     = run & ex_valid & ~q_empty;
  assign actual_next = (ex_isCF & ex_taken) ? ex_target : pc_plus4;
  assign mispredict  = (actual_next != head.pred);
  assign fetch_ready = ~q_full & run;

  // a full queue still takes a push when a good pop frees the slot
  assign push  = fetch_valid & run &
                 (~q_full | (resolve & ~mispredict));
  assign pop   = resolve;
  assign clear = resolve & mispredict;

  // next state, training, flush and statistics
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    pcu_d   = '0;
    tgt_d   = '0;
    tkn_d   = 1'b0;
    flush_d = 1'b0;
    redir_d = '0;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    perr_d  = perr_q;
    unique case (state_q)
      BRU_RUN: begin
        if (ex_valid && q_empty) perr_d = 1'b1;
        if (resolve) begin
          we_d  = ex_isCF;
          pcu_d = head.pc;
          tgt_d = ex_target;
          tkn_d = ex_taken;
          if (ex_isCF && bcnt_q != '1)
            bcnt_d = bcnt_q + 1'b1;
          if (mispredict) begin
            state_d = BRU_FLUSH;
            flush_d = 1'b1;
            redir_d = actual_next;
            if (mcnt_q != '1)
              mcnt_d = mcnt_q + 1'b1;
          end
        end
      end
      BRU_FLUSH: state_d = BRU_RUN;
      default:   state_d = BRU_RUN;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BRU_RUN;
      we_q    <= 1'b0;
      pcu_q   <= '0;
      tgt_q   <= '0;
      tkn_q   <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      pcu_q   <= pcu_d;
      tgt_q   <= tgt_d;
      tkn_q   <= tkn_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
      perr_q  <= perr_d;
    end
  end

  assign we              = we_q;
  assign PCUpdate        = pcu_q;
  assign targetUpdate    = tgt_q;
  assign takenUpdate     = tkn_q;
  assign flush           = flush_q;
  assign redirectPC      = redir_q;
  assign branchCount     = bcnt_q;
  assign mispredictCount = mcnt_q;
  assign protocol_error  = perr_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [63:0] fetch_PC;
  logic [63:0] fetch_PCPrediction;
  logic        fetch_ready;
  logic        ex_valid;
  logic        ex_isCF;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        we;
  logic [63:0] PCUpdate;
  logic [63:0] targetUpdate;
  logic        takenUpdate;
  logic        flush;
  logic [63:0] redirectPC;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;
  logic        protocol_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(
    .DEPTH (4),
    .CNT_W (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_valid        (fetch_valid),
    .fetch_PC           (fetch_PC),
    .fetch_PCPrediction (fetch_PCPrediction),
    .fetch_ready        (fetch_ready),
    .ex_valid           (ex_valid),
    .ex_isCF            (ex_isCF),
    .ex_taken           (ex_taken),
    .ex_target          (ex_target),
    .we                 (we),
    .PCUpdate           (PCUpdate),
    .targetUpdate       (targetUpdate),
    .takenUpdate        (takenUpdate),
    .flush              (flush),
    .redirectPC         (redirectPC),
    .branchCount        (branchCount),
    .mispredictCount    (mispredictCount),
    .protocol_error     (protocol_error)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0;
    ex_valid    = 1'b0;
    ex_isCF     = 1'b0;
    ex_taken    = 1'b0;
    ex_target   = '0;
  endtask

  task automatic fpush(input logic [63:0] pc,
                       input logic [63:0] pr);
    fetch_valid        = 1'b1;
    fetch_PC           = pc;
    fetch_PCPrediction = pr;
  endtask

  task automatic res(input logic cf,
                     input logic tk,
                     input logic [63:0] tg);
    ex_valid  = 1'b1;
    ex_isCF   = cf;
    ex_taken  = tk;
    ex_target = tg;
  endtask

  initial begin
    idle();
    fetch_PC           = '0;
    fetch_PCPrediction = '0;
    reset = 1'b0;
    #12;
    chk("rst_ready", fetch_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_bcnt", branchCount, 0);
    chk("rst_perr", protocol_error, 0);
    reset = 1'b1;
    tick();

    // 1: non-CF, correct prediction
    fpush(64'h100, 64'h104); tick();
    idle(); res(0, 0, 0); tick();
    idle();
    chk("t1_we", we, 0);
    chk("t1_flush", flush, 0);
    chk("t1_pcu", PCUpdate, 64'h100);
    chk("t1_bcnt", branchCount, 0);
    tick();

    // 2: taken branch, correct prediction
    fpush(64'h200, 64'h300); tick();
    idle(); res(1, 1, 64'h300); tick();
    idle();
    chk("t2_we", we, 1);
    chk("t2_pcu", PCUpdate, 64'h200);
    chk("t2_tgt", targetUpdate, 64'h300);
    chk("t2_tkn", takenUpdate, 1);
    chk("t2_flush", flush, 0);
    chk("t2_bcnt", branchCount, 1);
    tick();
    chk("t2_we_drop", we, 0);

    // 3: taken branch predicted not-taken
    fpush(64'h400, 64'h404); tick();
    idle(); res(1, 1, 64'h800); tick();
    idle();
    chk("t3_flush", flush, 1);
    chk("t3_redir", redirectPC, 64'h800);
    chk("t3_ready", fetch_ready, 0);
    chk("t3_mcnt", mispredictCount, 1);
    chk("t3_bcnt", branchCount, 2);
    tick();
    chk("t3_flush_end", flush, 0);
    chk("t3_ready_end", fetch_ready, 1);

    // 4: fill, push+pop while full, dropped push
    for (int i = 0; i < 4; i++) begin
      fpush(64'h1000 + 64'(4 * i), 64'h1004 + 64'(4 * i));
      tick();
    end
    idle();
    chk("t4_full", fetch_ready, 0);
    fpush(64'h2000, 64'h2004); res(0, 0, 0); tick();
    idle();
    chk("t4_pp_pcu", PCUpdate, 64'h1000);
    chk("t4_pp_flush", flush, 0);
    chk("t4_pp_full", fetch_ready, 0);
    fpush(64'h3000, 64'h3004); tick();
    idle();
    chk("t4_drop_full", fetch_ready, 0);
    begin
      logic [63:0] exp_pc [4];
      exp_pc[0] = 64'h1004;
      exp_pc[1] = 64'h1008;
      exp_pc[2] = 64'h100c;
      exp_pc[3] = 64'h2000;
      for (int i = 0; i < 4; i++) begin
        res(0, 0, 0); tick();
        idle();
        chk($sformatf("t4_drain%0d", i), PCUpdate, exp_pc[i]);
        chk($sformatf("t4_fl%0d", i), flush, 0);
      end
    end
    chk("t4_ready", fetch_ready, 1);

    // 5: resolve with empty queue
    res(1, 1, 64'h40); tick();
    idle();
    chk("t5_perr", protocol_error, 1);
    chk("t5_we", we, 0);
    chk("t5_bcnt", branchCount, 2);
    tick();
    chk("t5_sticky", protocol_error, 1);

    // 6: non-CF mispredict, then async reset in FLUSH
    fpush(64'h500, 64'h600); tick();
    idle(); res(0, 0, 0); tick();
    idle();
    chk("t6_flush", flush, 1);
    chk("t6_redir", redirectPC, 64'h504);
    chk("t6_mcnt", mispredictCount, 2);
    reset = 1'b0;
    #1;
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_ready", fetch_ready, 1);
    chk("t6_rst_bcnt", branchCount, 0);
    chk("t6_rst_mcnt", mispredictCount, 0);
    chk("t6_rst_perr", protocol_error, 0);
    chk("t6_rst_redir", redirectPC, 0);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
